// File: rtl/regfile_mp_pkg.sv
// Shared types and sizing helpers for the multi-port register file and its
// datapath neighbours (decoder, ALU, ImmGen).
package regfile_mp_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREGS = 32;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } rf_state_e;

  function automatic int addr_width(input int nregs);
    return (nregs < 2) ? 1 : $clog2(nregs);
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Port bundle of the multi-port register file: read/write ports, clear
// request, busy flag and the clear-FSM state for observation.
interface regfile_mp_if #(
  parameter int XLEN  = regfile_mp_pkg::DEF_XLEN,
  parameter int NREGS = regfile_mp_pkg::DEF_NREGS,
  parameter int NRD   = 2,
  parameter int NWR   = 1
) ();
  localparam int AW = regfile_mp_pkg::addr_width(NREGS);

  // No valid/ready pairs here: we[k] alone qualifies waddr/wdata of port k
  // for the next edge, reads are pure combinational lookups, and a clr_req
  // pulse is accepted only in a cycle where busy is low.
  logic                   clr_req;
  logic                   busy;
  logic [NWR-1:0]         we;
  logic [NWR*AW-1:0]      waddr;
  logic [NWR*XLEN-1:0]    wdata;
  logic [NRD*AW-1:0]      raddr;
  logic [NRD*XLEN-1:0]    rdata;
  regfile_mp_pkg::rf_state_e state;

  modport master (
    output clr_req, we, waddr, wdata, raddr,
    input  busy, rdata, state
  );

  modport slave (
    input  clr_req, we, waddr, wdata, raddr,
    output busy, rdata, state
  );

endinterface

// File: rtl/regfile_clr_seq.sv
// Clear sequencer: walks an index over every register, one per cycle, after
// reset or on request, then idles in READY.
module regfile_clr_seq
  import regfile_mp_pkg::*;
#(
  parameter  int NREGS = DEF_NREGS,
  localparam int AW    = addr_width(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_req,
  output logic          busy,
  output logic          clr_en,
  output logic [AW-1:0] clr_idx,
  output rf_state_e     state
);

  // One spare bit so the counter can step past the last index without wrapping.
  localparam logic [AW:0] CNT_LAST = (AW+1)'(NREGS - 1);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

  rf_state_e   state_q, state_d;
  logic [AW:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) state_d = ST_READY;
      end
      ST_READY: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
    endcase
  end

  assign busy    = (state_q == ST_CLEAR);
  assign clr_en  = busy;
  assign clr_idx = cnt_q[AW-1:0];
  assign state   = state_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with optional zero register,
// write-to-read bypass and a sequential clear sweep.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int XLEN     = DEF_XLEN,
  parameter int NREGS    = DEF_NREGS,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic         clk,
  input logic         rst,
  regfile_mp_if.slave bus
);

  localparam int AW = addr_width(NREGS);

  logic          busy;
  logic          clr_en;
  logic [AW-1:0] clr_idx;
  rf_state_e     state;

  regfile_clr_seq #(.NREGS(NREGS)) u_clr_seq (
    .clk     (clk),
    .rst     (rst),
    .clr_req (bus.clr_req),
    .busy    (busy),
    .clr_en  (clr_en),
    .clr_idx (clr_idx),
    .state   (state)
  );

  logic [XLEN-1:0] mem_q [NREGS];
  logic [XLEN-1:0] mem_d [NREGS];

  // Ascending port order makes the higher-numbered port win on equal indices.
  always_comb begin
    mem_d = mem_q;
    if (clr_en) begin
      mem_d[clr_idx] = '0;
    end else begin
      for (int k = 0; k < NWR; k++) begin
        if (bus.we[k] && !((ZERO_REG != 0) && (bus.waddr[k*AW +: AW] == '0))) begin
          mem_d[bus.waddr[k*AW +: AW]] = bus.wdata[k*XLEN +: XLEN];
        end
      end
    end
  end

  // The array has no reset of its own; the sweep that follows reset zeroes it.
  always_ff @(posedge clk) begin
    if (!rst) mem_q <= mem_d;
  end

  logic [NRD*XLEN-1:0] rdata_c;
  logic [AW-1:0]       ridx;
  logic [XLEN-1:0]     rval;

  always_comb begin
    rdata_c = '0;
    ridx    = '0;
    rval    = '0;
    for (int j = 0; j < NRD; j++) begin
      ridx = bus.raddr[j*AW +: AW];
      rval = mem_q[ridx];
      if (BYPASS != 0) begin
        for (int k = 0; k < NWR; k++) begin
          if (bus.we[k] && (bus.waddr[k*AW +: AW] == ridx)) rval = bus.wdata[k*XLEN +: XLEN];
        end
      end
      if (busy || ((ZERO_REG != 0) && (ridx == '0))) rval = '0;
      rdata_c[j*XLEN +: XLEN] = rval;
    end
  end

  assign bus.rdata = rdata_c;
  assign bus.busy  = busy;
  assign bus.state = state;

endmodule
